// File: rtl/divider_8by4_pkg.sv
// Shared constants and state type for the 8-by-4 sequential restoring divider.
package divider_pkg;

    localparam int unsigned N_W = 8;
    localparam int unsigned D_W = 4;

    localparam logic [N_W-1:0] Q_DZ = 8'hFF;
    localparam logic [D_W-1:0] R_DZ = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_8by4_adder_subtractor5.sv
// 5-bit ripple-carry adder/subtractor: S = A + (B ^ {5{P}}) + P, built from half adders.
module adder_subtractor5 (
    input  logic [4:0] A,
    input  logic [4:0] B,
    input  logic       P,
    output logic [4:0] S,
    output logic       CO
);

    logic [5:0] c;
    logic [4:0] bx;
    logic [4:0] h1_s;
    logic [4:0] h1_c;
    logic [4:0] h2_c;

    always_comb begin
        c    = '0;
        bx   = '0;
        h1_s = '0;
        h1_c = '0;
        h2_c = '0;
        S    = '0;
        c[0] = P;
        // Each full adder is two half adders plus an OR of their carries.
        for (int unsigned i = 0; i < 5; i++) begin
            bx[i]   = B[i] ^ P;
            h1_s[i] = A[i] ^ bx[i];
            h1_c[i] = A[i] & bx[i];
            S[i]    = h1_s[i] ^ c[i];
            h2_c[i] = h1_s[i] & c[i];
            c[i+1]  = h1_c[i] | h2_c[i];
        end
    end

    assign CO = c[5];

endmodule

// File: rtl/divider_8by4.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one shift-subtract step per clock.
module divider_8by4 (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] N,
    input  logic [3:0] D,
    output logic [7:0] Q,
    output logic [3:0] R,
    output logic       DZ,
    output logic       BUSY,
    output logic       DONE
);

    import divider_pkg::*;

    // The DONE port hides the package literal of the same name, so states are package-qualified.
    state_t     state_q, state_d;
    logic [2:0] cnt_q;
    logic [7:0] nreg_q;
    logic [3:0] dreg_q;
    logic [3:0] rem_q;

    logic [4:0] trial;
    logic [4:0] diff;
    logic       no_borrow;
    logic [3:0] rem_next;
    logic       accept;

    assign trial = {rem_q, nreg_q[7]};

    adder_subtractor5 u_addsub (
        .A  (trial),
        .B  ({1'b0, dreg_q}),
        .P  (1'b1),
        .S  (diff),
        .CO (no_borrow)
    );

    assign rem_next = no_borrow ? diff[3:0] : trial[3:0];
    assign accept   = (state_q == divider_pkg::IDLE) && START;

    always_comb begin
        state_d = state_q;
        case (state_q)
            divider_pkg::IDLE: if (START) state_d = (D == '0) ? divider_pkg::DONE : divider_pkg::RUN;
            divider_pkg::RUN:  if (cnt_q == 3'd7) state_d = divider_pkg::DONE;
            divider_pkg::DONE: state_d = divider_pkg::IDLE;
            default:           state_d = divider_pkg::IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= divider_pkg::IDLE;
            cnt_q   <= '0;
            nreg_q  <= '0;
            dreg_q  <= '0;
            rem_q   <= '0;
            Q       <= '0;
            R       <= '0;
            DZ      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (D == '0) begin
                    Q  <= Q_DZ;
                    R  <= R_DZ;
                    DZ <= 1'b1;
                end else begin
                    nreg_q <= N;
                    dreg_q <= D;
                    rem_q  <= '0;
                    cnt_q  <= '0;
                end
            end else if (state_q == divider_pkg::RUN) begin
                nreg_q <= {nreg_q[6:0], no_borrow};
                rem_q  <= rem_next;
                cnt_q  <= cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    Q  <= {nreg_q[6:0], no_borrow};
                    R  <= rem_next;
                    DZ <= 1'b0;
                end
            end
        end
    end

    // rem < D on entry to every step keeps the trial value within 5 bits.
    always_ff @(posedge CLK) begin
        if (!RST && state_q == divider_pkg::RUN) begin
            assert (!(no_borrow && diff[4]));
        end
    end

    assign BUSY = (state_q == divider_pkg::RUN);
    assign DONE = (state_q == divider_pkg::DONE);

endmodule

// File: tb/tb_divider_8by4.sv
// Directed-vector bench for divider_8by4 with hand-computed results and a full operand sweep.
module tb_divider_8by4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic [7:0] N = '0;
    logic [3:0] D = '0;
    logic [7:0] Q;
    logic [3:0] R;
    logic       DZ;
    logic       BUSY;
    logic       DONE;

    int n_checks = 0;
    int n_errors = 0;

    divider_8by4 dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .N     (N),
        .D     (D),
        .Q     (Q),
        .R     (R),
        .DZ    (DZ),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issues one START and waits (bounded) for DONE; reports latency, busy cycles and overlap faults.
    task automatic run_div(input logic [7:0] n, input logic [3:0] d,
                           output int lat, output int busy_cnt, output int hold_bad, output int overlap);
        logic [7:0] pq;
        logic [3:0] pr;
        logic       pdz;
        pq = Q; pr = R; pdz = DZ;
        lat = 0; busy_cnt = 0; hold_bad = 0; overlap = 0;
        START = 1'b1; N = n; D = d;
        tick();
        START = 1'b0; N = $urandom_range(255); D = 4'($urandom_range(15));
        while (!DONE && lat < 20) begin
            if (BUSY) busy_cnt++;
            if (Q != pq || R != pr || DZ != pdz) hold_bad++;
            tick();
            lat++;
        end
        if (BUSY && DONE) overlap++;
    endtask

    task automatic dir(input string tag, input logic [7:0] n, input logic [3:0] d,
                       input int eq, input int er, input int edz, input int elat);
        int lat, bc, hb, ov;
        run_div(n, d, lat, bc, hb, ov);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_busy"}, bc, elat);
        check({tag, "_hold"}, hb, 0);
        check({tag, "_overlap"}, ov, 0);
        check({tag, "_q"}, int'(Q), eq);
        check({tag, "_r"}, int'(R), er);
        check({tag, "_dz"}, int'(DZ), edz);
        tick();
        check({tag, "_done_1cyc"}, int'(DONE), 0);
        check({tag, "_q_held"}, int'(Q), eq);
    endtask

    initial begin
        int lat, bc, hb, ov, pulses, cq, cr, bad;

        repeat (3) tick();
        check("rst_q", int'(Q), 0);
        check("rst_r", int'(R), 0);
        check("rst_dz", int'(DZ), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_done", int'(DONE), 0);
        // START alongside RST must be ignored.
        START = 1'b1; N = 8'd143; D = 4'd11;
        tick();
        START = 1'b0; RST = 1'b0;
        tick();
        check("rst_start_ignored", int'(BUSY | DONE), 0);

        dir("143_11", 8'd143, 4'd11, 13, 0, 0, 8);
        dir("200_7", 8'd200, 4'd7, 28, 4, 0, 8);
        dir("255_1", 8'd255, 4'd1, 255, 0, 0, 8);
        dir("5_15", 8'd5, 4'd15, 0, 5, 0, 8);
        dir("77_0", 8'd77, 4'd0, 255, 15, 1, 0);
        dir("9_3", 8'd9, 4'd3, 3, 0, 0, 8);

        // Operand and START activity during RUN must not disturb the result.
        START = 1'b1; N = 8'd100; D = 4'd3;
        tick();
        START = 1'b0;
        tick();
        START = 1'b1; N = 8'd1; D = 4'd1;
        repeat (5) tick();
        START = 1'b0;
        pulses = 0; cq = -1; cr = -1;
        for (int i = 0; i < 12; i++) begin
            if (DONE) begin
                pulses++;
                cq = int'(Q);
                cr = int'(R);
            end
            if (BUSY && DONE) pulses += 100;
            tick();
        end
        check("ignore_pulses", pulses, 1);
        check("ignore_q", cq, 33);
        check("ignore_r", cr, 1);

        // Reset at edge 4 of a run.
        START = 1'b1; N = 8'd250; D = 4'd9;
        tick();
        START = 1'b0;
        repeat (3) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("midrst_q", int'(Q), 0);
        check("midrst_r", int'(R), 0);
        check("midrst_dz", int'(DZ), 0);
        check("midrst_busy", int'(BUSY), 0);
        check("midrst_done", int'(DONE), 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (DONE || BUSY) pulses++;
            tick();
        end
        check("midrst_idle", pulses, 0);
        dir("250_9", 8'd250, 4'd9, 27, 7, 0, 8);

        // Full sweep of nonzero divisors against integer division.
        bad = 0;
        for (int d = 1; d < 16; d++) begin
            for (int n = 0; n < 256; n++) begin
                run_div(8'(n), 4'(d), lat, bc, hb, ov);
                if (lat != 8 || ov != 0 || DZ != 1'b0 ||
                    int'(Q) != n / d || int'(R) != n % d ||
                    int'(Q) * d + int'(R) != n || int'(R) >= d) begin
                    if (bad < 5) $display("sweep n=%0d d=%0d q=%0d r=%0d lat=%0d", n, d, Q, R, lat);
                    bad++;
                end
                tick();
            end
        end
        check("sweep_bad", bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
